// File: rtl/countdown_timer_if.sv
// countdown_timer_if: control and status bundle of the countdown timer.
// master drives load/preset/continue_pause; slave (the timer) drives status.
interface countdown_timer_if #(
    parameter int SECONDS_WIDTH = 10
);
    logic                     load;
    logic [SECONDS_WIDTH-1:0] preset;
    logic                     continue_pause;
    logic [SECONDS_WIDTH-1:0] seconds_left;
    logic                     running;
    logic                     expired;
    logic                     expired_pulse;

    modport master (
        output load,
        output preset,
        output continue_pause,
        input  seconds_left,
        input  running,
        input  expired,
        input  expired_pulse
    );

    modport slave (
        input  load,
        input  preset,
        input  continue_pause,
        output seconds_left,
        output running,
        output expired,
        output expired_pulse
    );
endinterface

// File: rtl/countdown_timer.sv
// countdown_timer: preset-loaded seconds countdown with pause/resume.
// Define AUTO_RELOAD_EN to reload the preset on expiry instead of stopping.
module countdown_timer #(
    parameter int SECONDS_WIDTH    = 10,
    parameter int TICKS_PER_SECOND = 50000000
) (
    input  logic             clk,
    input  logic             async_reset,
    countdown_timer_if.slave bus
);
    localparam int PW = (TICKS_PER_SECOND > 2) ?
                        $clog2(TICKS_PER_SECOND) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICKS_PER_SECOND - 1);
    localparam logic [SECONDS_WIDTH-1:0] ONE = SECONDS_WIDTH'(1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] PAUSED  = 2'd1;
    localparam logic [1:0] RUN     = 2'd2;
    localparam logic [1:0] EXPIRED = 2'd3;

    logic [1:0]               state_q;
    logic [1:0]               state_d;
    logic [SECONDS_WIDTH-1:0] count_q;
    logic [SECONDS_WIDTH-1:0] count_d;
    logic [PW-1:0]            pre_q;
    logic [PW-1:0]            pre_d;
    logic                     pulse_q;
    logic                     pulse_d;
    logic                     running_q;
    logic                     expired_q;
    logic                     tick;

`ifdef AUTO_RELOAD_EN
    logic [SECONDS_WIDTH-1:0] preset_q;
    logic [SECONDS_WIDTH-1:0] preset_d;
`endif

    assign tick = (state_q == RUN) && (pre_q == PRE_MAX);

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        pre_d    = pre_q;
        pulse_d  = 1'b0;
`ifdef AUTO_RELOAD_EN
        preset_d = preset_q;
`endif
        if (bus.load) begin
            // load overrides any pause request or tick in the same cycle
            count_d  = bus.preset;
            pre_d    = '0;
            state_d  = (bus.preset != '0) ? PAUSED : IDLE;
`ifdef AUTO_RELOAD_EN
            preset_d = bus.preset;
`endif
        end else begin
            unique case (state_q)
                RUN: begin
                    pre_d = tick ? '0 : pre_q + 1'b1;
                    if (tick) begin
                        if (count_q > ONE) begin
                            count_d = count_q - 1'b1;
                        end else begin
                            pulse_d = 1'b1;
`ifdef AUTO_RELOAD_EN
                            count_d = preset_q;
`else
                            count_d = '0;
                            state_d = EXPIRED;
`endif
                        end
                    end
                    // a pause only takes effect if the tick did not expire
                    if (bus.continue_pause && state_d != EXPIRED) begin
                        state_d = PAUSED;
                    end
                end
                PAUSED: begin
                    if (bus.continue_pause) begin
                        state_d = RUN;
                    end
                end
                IDLE: begin
                    state_d = IDLE;
                end
                EXPIRED: begin
                    state_d = EXPIRED;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            pre_q     <= '0;
            pulse_q   <= 1'b0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            pre_q     <= pre_d;
            pulse_q   <= pulse_d;
            running_q <= (state_d == RUN);
            expired_q <= (state_d == EXPIRED);
        end
    end

`ifdef AUTO_RELOAD_EN
    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            preset_q <= '0;
        end else begin
            preset_q <= preset_d;
        end
    end
`endif

    assign bus.seconds_left  = count_q;
    assign bus.running       = running_q;
    assign bus.expired       = expired_q;
    assign bus.expired_pulse = pulse_q;

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed bench with an elapsed-run-time reference model.
// Honours AUTO_RELOAD_EN the same way the design does.
module tb_countdown_timer;
    localparam int SW  = 10;
    localparam int TPS = 4;

    logic clk = 1'b0;
    logic async_reset = 1'b0;
    bit   chk_en = 1'b0;
    int   checks = 0;
    int   failures = 0;

    // model: mode 0 idle, 1 paused, 2 run, 3 expired
    int m_mode = 0;
    int m_loaded = 0;
    int m_rc = 0;
    bit m_pulse = 1'b0;

    countdown_timer_if #(.SECONDS_WIDTH(SW)) bus ();

    countdown_timer #(
        .SECONDS_WIDTH(SW),
        .TICKS_PER_SECOND(TPS)
    ) dut (
        .clk(clk),
        .async_reset(async_reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic int exp_secs();
        if (m_mode == 0) return 0;
`ifdef AUTO_RELOAD_EN
        return m_loaded - ((m_rc / TPS) % m_loaded);
`else
        return m_loaded - (m_rc / TPS);
`endif
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_loaded = 0;
        m_rc = 0;
        m_pulse = 1'b0;
    endtask

    // m_rc counts cycles spent in RUN since the last load
    task automatic model_update(input bit ld, input int pv, input bit cp);
        m_pulse = 1'b0;
        if (ld) begin
            m_loaded = pv;
            m_rc = 0;
            m_mode = (pv != 0) ? 1 : 0;
        end else if (m_mode == 2) begin
            m_rc++;
`ifdef AUTO_RELOAD_EN
            if (m_rc % (TPS * m_loaded) == 0) m_pulse = 1'b1;
`else
            if (m_rc == TPS * m_loaded) begin
                m_pulse = 1'b1;
                m_mode = 3;
            end
`endif
            if (cp && m_mode == 2) m_mode = 1;
        end else if (m_mode == 1 && cp) begin
            m_mode = 2;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("seconds_left", int'(bus.seconds_left), exp_secs());
            check("running", int'(bus.running), int'(m_mode == 2));
            check("expired", int'(bus.expired), int'(m_mode == 3));
            check("expired_pulse", int'(bus.expired_pulse), int'(m_pulse));
        end
    end

    task automatic step(input bit ld, input int pv, input bit cp);
        bus.load = ld;
        bus.preset = SW'(pv);
        bus.continue_pause = cp;
        @(posedge clk);
        model_update(ld, pv, cp);
        @(negedge clk);
        bus.load = 1'b0;
        bus.preset = '0;
        bus.continue_pause = 1'b0;
    endtask

    task automatic lit(input string name, input int got, input int exp);
        check({"lit_", name}, got, exp);
    endtask

    task automatic lit_all_zero(input string tag);
        lit({tag, "_secs"}, int'(bus.seconds_left), 0);
        lit({tag, "_running"}, int'(bus.running), 0);
        lit({tag, "_expired"}, int'(bus.expired), 0);
        lit({tag, "_pulse"}, int'(bus.expired_pulse), 0);
    endtask

    task automatic mid_cycle_reset();
        #2 async_reset = 1'b1;
        model_reset();
        #1 lit_all_zero("async_rst");
        @(negedge clk);
        async_reset = 1'b0;
    endtask

    initial begin
        bus.load = 1'b0;
        bus.preset = '0;
        bus.continue_pause = 1'b0;
        #1 async_reset = 1'b1;
        repeat (2) @(negedge clk);
        lit_all_zero("reset");
        async_reset = 1'b0;
        chk_en = 1'b1;

        // basic countdown from 3
        step(1'b1, 3, 1'b0);
        lit("load3_secs", int'(bus.seconds_left), 3);
        lit("load3_running", int'(bus.running), 0);
        step(1'b0, 0, 1'b1);
        lit("start_running", int'(bus.running), 1);
        repeat (11) step(1'b0, 0, 1'b0);
        lit("pre_zero_secs", int'(bus.seconds_left), 1);
        step(1'b0, 0, 1'b0);
        lit("zero_pulse", int'(bus.expired_pulse), 1);
`ifdef AUTO_RELOAD_EN
        lit("zero_secs", int'(bus.seconds_left), 3);
        lit("zero_expired", int'(bus.expired), 0);
        lit("zero_running", int'(bus.running), 1);
`else
        lit("zero_secs", int'(bus.seconds_left), 0);
        lit("zero_expired", int'(bus.expired), 1);
        lit("zero_running", int'(bus.running), 0);
`endif
        step(1'b0, 0, 1'b0);
        lit("pulse_once", int'(bus.expired_pulse), 0);
        step(1'b0, 0, 1'b1);
`ifndef AUTO_RELOAD_EN
        lit("exp_cp_expired", int'(bus.expired), 1);
        lit("exp_cp_secs", int'(bus.seconds_left), 0);
`endif

        // pause keeps the partial second
        step(1'b1, 5, 1'b0);
        step(1'b0, 0, 1'b1);
        repeat (5) step(1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b1);
        lit("paused_secs", int'(bus.seconds_left), 4);
        lit("paused_running", int'(bus.running), 0);
        repeat (20) step(1'b0, 0, 1'b0);
        lit("hold_secs", int'(bus.seconds_left), 4);
        step(1'b0, 0, 1'b1);
        lit("resume_running", int'(bus.running), 1);
        step(1'b0, 0, 1'b0);
        lit("resume1_secs", int'(bus.seconds_left), 4);
        step(1'b0, 0, 1'b0);
        lit("resume2_secs", int'(bus.seconds_left), 3);

        // collisions
        step(1'b0, 0, 1'b1);
        step(1'b1, 7, 1'b1);
        lit("ldcp_secs", int'(bus.seconds_left), 7);
        lit("ldcp_running", int'(bus.running), 0);
        step(1'b0, 0, 1'b1);
        repeat (3) step(1'b0, 0, 1'b0);
        step(1'b1, 6, 1'b0);
        lit("ldtick_secs", int'(bus.seconds_left), 6);
        lit("ldtick_pulse", int'(bus.expired_pulse), 0);
        step(1'b1, 1, 1'b0);
        step(1'b0, 0, 1'b1);
        repeat (3) step(1'b0, 0, 1'b0);
        step(1'b1, 2, 1'b0);
        lit("ldexp_secs", int'(bus.seconds_left), 2);
        lit("ldexp_pulse", int'(bus.expired_pulse), 0);
        lit("ldexp_expired", int'(bus.expired), 0);
        step(1'b0, 0, 1'b1);
        repeat (3) step(1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b1);
        lit("cptick_secs", int'(bus.seconds_left), 1);
        lit("cptick_running", int'(bus.running), 0);
        step(1'b0, 0, 1'b1);
        repeat (3) step(1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b1);
        lit("cpexp_pulse", int'(bus.expired_pulse), 1);
        lit("cpexp_running", int'(bus.running), 0);
`ifndef AUTO_RELOAD_EN
        lit("cpexp_expired", int'(bus.expired), 1);
        step(1'b0, 0, 1'b1);
        lit("expcp_secs", int'(bus.seconds_left), 0);
        lit("expcp_expired", int'(bus.expired), 1);
`endif

        // zero preset and reset mid-run
        step(1'b1, 0, 1'b0);
        lit("ld0_secs", int'(bus.seconds_left), 0);
        lit("ld0_expired", int'(bus.expired), 0);
        step(1'b0, 0, 1'b1);
        lit("idle_cp_running", int'(bus.running), 0);
        step(1'b1, 10, 1'b0);
        step(1'b0, 0, 1'b1);
        repeat (4) step(1'b0, 0, 1'b0);
        lit("pre_rst_secs", int'(bus.seconds_left), 9);
        mid_cycle_reset();
        step(1'b0, 0, 1'b1);
        lit("post_rst_running", int'(bus.running), 0);

        // long run of preset 2 (reload sequence when enabled)
        step(1'b1, 2, 1'b0);
        step(1'b0, 0, 1'b1);
        repeat (8) step(1'b0, 0, 1'b0);
`ifdef AUTO_RELOAD_EN
        lit("wrap_secs", int'(bus.seconds_left), 2);
        lit("wrap_pulse", int'(bus.expired_pulse), 1);
        lit("wrap_expired", int'(bus.expired), 0);
        lit("wrap_running", int'(bus.running), 1);
`else
        lit("run2_expired", int'(bus.expired), 1);
`endif
        repeat (12) step(1'b0, 0, 1'b0);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
